// File: rtl/mul_seq_sched.sv
// Round-robin scheduler feeding one shared constant-multiplier sequence (x1, x3, x7, x8).
// Each granted operand yields four tagged results on consecutive cycles; jobs chain without gaps.
module mul_seq_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int OW   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] d_bus,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [OW-1:0]      out,
  output logic               out_valid,
  output logic [1:0]         out_phase,
  output logic [1:0]         out_id,
  output logic               done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [DW-1:0]     r_op;
  logic [1:0]        r_id;
  logic [1:0]        r_last;
  logic [NREQ-1:0]   r_grant;
  logic [OW-1:0]     r_out;
  logic              r_out_valid;
  logic [1:0]        r_out_phase;
  logic [1:0]        r_out_id;
  logic              r_done;

  logic              w_arb;
  logic              w_found;
  logic [1:0]        w_winner;
  logic [DW-1:0]     w_op_sel;
  logic [NREQ-1:0]   w_grant_nxt;
  logic              w_last_phase;

  // Shift-and-add product for one phase; all terms are formed at OW bits.
  function automatic logic [OW-1:0] phase_product(input logic [DW-1:0] op, input logic [1:0] ph);
    logic [OW-1:0] v_op;
    v_op = OW'(op);
    case (ph)
      2'd0:    phase_product = v_op;
      2'd1:    phase_product = (v_op << 3'd1) + v_op;
      2'd2:    phase_product = (v_op << 3'd3) - v_op;
      2'd3:    phase_product = v_op << 3'd3;
      default: phase_product = {OW{1'b0}};
    endcase
  endfunction

  // Circular priority search starting one past the last winner.
  always_comb begin
    int v_idx;
    w_found  = 1'b0;
    w_winner = 2'd0;
    w_op_sel = {DW{1'b0}};
    v_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = (int'(r_last) + k) % NREQ;
      if (!w_found && req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx[1:0];
        w_op_sel = d_bus[v_idx*DW +: DW];
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Next-state decode: arbitration is allowed only when idle or on the final phase.
  always_comb begin
    w_last_phase = (r_state == ST_RUN) && (r_cnt == 2'd3);
    w_arb        = (req != {NREQ{1'b0}}) && ((r_state == ST_IDLE) || w_last_phase);
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = {NREQ{1'b0}};
    if (w_arb) begin
      w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    end else begin
      w_grant_nxt = {NREQ{1'b0}};
    end
    case (r_state)
      ST_IDLE: begin
        if (w_arb) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_RUN: begin
        if (w_arb) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 2'd0;
        end else if (w_last_phase) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = r_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Control state, job latches and arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_op    <= {DW{1'b0}};
      r_id    <= 2'd0;
      r_last  <= 2'(NREQ - 1);
      r_grant <= {NREQ{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      if (w_arb) begin
        r_op   <= w_op_sel;
        r_id   <= w_winner;
        r_last <= w_winner;
      end else begin
        r_op   <= r_op;
        r_id   <= r_id;
        r_last <= r_last;
      end
    end
  end

  // Result pipeline; the phase-3 result still uses the old operand on a back-to-back edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= {OW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_phase <= 2'd0;
      r_out_id    <= 2'd0;
      r_done      <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_out       <= phase_product(r_op, r_cnt);
      r_out_valid <= 1'b1;
      r_out_phase <= r_cnt;
      r_out_id    <= r_id;
      r_done      <= (r_cnt == 2'd3);
    end else begin
      r_out       <= r_out;
      r_out_valid <= 1'b0;
      r_out_phase <= r_out_phase;
      r_out_id    <= r_out_id;
      r_done      <= 1'b0;
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state == ST_RUN);
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_phase = r_out_phase;
  assign out_id    = r_out_id;
  assign done      = r_done;

endmodule

// File: doc/mul_seq_sched.md
# mul_seq_sched

Round-robin scheduler that shares one sequenced constant-multiplier datapath among up to four requesters. Each granted operand is run through the fixed four-phase sequence ×1, ×3, ×7, ×8, one result per cycle, tagged with requester ID and phase. It sits between independent producers and the shared multiply resource. It replaces per-producer multiplier instances and sequences back-to-back jobs with no idle cycle.

## Interface
- NREQ, 4: number of requesters; valid range 2–4, so the ID fits 2 bits.
- DW, 8: operand width.
- OW, 11: result width; must be ≥ DW+3.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; level, held until grant
- d_bus  in  NREQ*DW  operands; requester i at bits [i*DW +: DW]; stable while req[i]=1
- grant  out  NREQ  one-hot, one-cycle pulse; operand of that requester captured
- busy  out  1  job in progress; equals (state==RUN)
- out  out  OW  result; holds its last value when out_valid=0
- out_valid  out  1  out is a valid phase result
- out_phase  out  2  0..3, selecting ×1/×3/×7/×8
- out_id  out  2  requester index of the current result
- done  out  1  pulses together with the phase-3 result

## Operation
- States:
  - IDLE: no job; out_valid=0.
  - RUN: cnt (2 bits) indexes the phase; op (DW bits) and id are latched.
- Arbitration happens at an edge where state==IDLE, or where state==RUN with cnt==3, and req≠0.
  - Winner is the first set req bit, searching circularly from last+1.
  - last updates to the winner.
  - Reset value of last is NREQ-1, so requester 0 has first priority.
- On arbitration:
  - op ← d_bus slice of the winner; id ← winner; cnt ← 0; state ← RUN.
  - grant ← one-hot(winner) for exactly one cycle.
- At each edge in RUN:
  - out ← op×{1,3,7,8}[cnt], zero-extended to OW.
  - out_valid ← 1; out_phase ← cnt; out_id ← id; cnt ← cnt+1.
- Phase arithmetic:
  - ×1 = op
  - ×3 = (op<<1)+op
  - ×7 = (op<<3)−op
  - ×8 = op<<3
  - All terms are computed at OW bits; no truncation for DW=8 (maximum 2040).
- At the cnt==3 edge: done ← 1.
  - If req≠0, a new job is arbitrated at the same edge (back-to-back). The phase-3 output uses the old op; the new op is latched simultaneously.
  - Otherwise state ← IDLE.
- A new request arriving while RUN at cnt 0..2 waits; it is not preempted.
- A req dropped before its grant is simply not served.
- If a requester keeps req high after its grant, this is treated as a new request in the next arbitration.
- Reset asserted mid-job aborts the job:
  - No done is produced and no partial results follow.
  - last returns to NREQ-1.

## Timing
- Reset values: grant=0, busy=0, out=0, out_valid=0, out_phase=0, out_id=0, done=0, state=IDLE, cnt=0, last=NREQ-1.
- Edge E0 arbitrates. Then:
  - Cycle after E0: grant high; busy high.
  - Edges E1..E4 produce phases 0..3; out_valid is high in the cycles after E1..E4.
  - done is high only after E4.
- Latency from the sampled req to the first result: 2 edges. Job length: 4 result cycles.
- Back-to-back throughput: one job per 4 cycles.
  - The new grant is high in the same cycle as done.
  - The new phase 0 follows immediately, with no out_valid gap.
- Without a pending request:
  - out_valid=0 and busy=0 in the cycle after done.
  - out keeps the ×8 value.
- grant, out_valid, done and all outputs are registered; busy decodes directly from the state register.

## Test plan
- Reset then single job: req=0001, d0=255.
  - Expect grant=0001 for one cycle.
  - Results 255, 765, 1785, 2040 with out_id=0 and phases 0..3.
  - done with 2040; busy drops next cycle.
- Boundary operands: d=0 gives 0,0,0,0; d=1 gives 1,3,7,8; d=128 gives 128,384,896,1024.
- Round-robin: req=1111 held constant, d_i=i+1.
  - Grant order 0,1,2,3,0.
  - Continuous out_valid with no bubble.
  - Each done coincides with the next grant.
  - out_id sequence follows the grant order.
- Late request: req[2] rises during cnt=1 of a requester-0 job.
  - No preemption.
  - grant=0100 in the done cycle; requester-2 phase 0 on the next cycle.
- Reset mid-job: assert rst during phase 2.
  - All outputs 0 immediately.
  - No done.
  - After release with req=1000|0001, requester 0 is granted first.
- Idle hold: after a job with no further req, out_valid=0, busy=0, and out holds the last ×8 value indefinitely.
